// File: rtl/uart_pkg.sv
// Shared UART definitions: baud timing helpers (also used by uart_tx),
// receiver state encoding and a 2-of-3 vote helper.
package uart_pkg;

    localparam int CNT_W = 11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_e;

    function automatic int bit_period(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic int half_period(input int clk_freq, input int baud_rate);
        return bit_period(clk_freq, baud_rate) / 2;
    endfunction

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for an asynchronous input; RESET_VAL selects the
// value both flops take during reset (1 for an idle-high line).
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_i,
    output logic sync_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
        end
    end

    assign sync_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and registered strobes.
// Optional UART_RX_MAJORITY_EN: 2-of-3 vote around each sample centre.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD_RATE = 9600
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int BIT_PERIOD  = bit_period(CLK_FREQ, BAUD_RATE);
    localparam int HALF_PERIOD = half_period(CLK_FREQ, BAUD_RATE);
`ifdef UART_RX_MAJORITY_EN
    localparam int SPACING = BIT_PERIOD / 16;
`else
    localparam int SPACING = 0;
`endif
    // Decisions happen SPACING after the centre; reloading the counter with
    // SPACING keeps later centres aligned to the true bit grid.
    localparam logic [CNT_W-1:0] START_DECIDE = CNT_W'(HALF_PERIOD - 1 + SPACING);
    localparam logic [CNT_W-1:0] BIT_DECIDE   = CNT_W'(BIT_PERIOD - 1 + SPACING);
    localparam logic [CNT_W-1:0] CNT_RELOAD   = CNT_W'(SPACING);

    logic             rx_s;
    rx_state_e        state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [3:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             data_valid_q;
    logic             framing_error_q;
    logic [CNT_W-1:0] decide_cnt_d;
    logic             decide_d;
    logic             bit_val_d;

    uart_rx_sync #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .async_i (rx),
        .sync_o  (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vote_q <= 2'b11;
        end else begin
            if (baud_cnt_q == decide_cnt_d - CNT_W'(2 * SPACING)) begin
                vote_q[0] <= rx_s;
            end
            if (baud_cnt_q == decide_cnt_d - CNT_W'(SPACING)) begin
                vote_q[1] <= rx_s;
            end
        end
    end

    always_comb begin
        bit_val_d = majority3(vote_q[0], vote_q[1], rx_s);
    end
`else
    always_comb begin
        bit_val_d = rx_s;
    end
`endif

    always_comb begin
        decide_cnt_d = (state_q == START) ? START_DECIDE : BIT_DECIDE;
        decide_d     = (baud_cnt_q == decide_cnt_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            baud_cnt_q      <= '0;
            bit_idx_q       <= '0;
            shift_q         <= '0;
            data_q          <= '0;
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
        end else begin
            data_valid_q    <= 1'b0;
            framing_error_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q    <= START;
                        baud_cnt_q <= '0;
                    end
                end
                START: begin
                    if (decide_d) begin
                        if (!bit_val_d) begin
                            state_q    <= DATA;
                            baud_cnt_q <= CNT_RELOAD;
                            bit_idx_q  <= '0;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (decide_d) begin
                        shift_q    <= {bit_val_d, shift_q[7:1]};
                        baud_cnt_q <= CNT_RELOAD;
                        bit_idx_q  <= bit_idx_q + 4'd1;
                        if (bit_idx_q == 4'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (decide_d) begin
                        baud_cnt_q <= '0;
                        if (bit_val_d) begin
                            data_q       <= shift_q;
                            data_valid_q <= 1'b1;
                            state_q      <= IDLE;
                        end else begin
                            framing_error_q <= 1'b1;
                            state_q         <= WAIT_IDLE;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_W'(1);
                    end
                end
                WAIT_IDLE: begin
                    // A held-low line must not be mistaken for a new start bit.
                    if (rx_s) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data          = data_q;
    assign data_valid    = data_valid_q;
    assign framing_error = framing_error_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: expected strobes are queued as frames are
// driven and matched when the receiver emits data_valid/framing_error.
module tb_uart_rx;

    localparam int CLK_FREQ = 3840000;
    localparam int BAUD     = 9600;
    localparam int BIT      = CLK_FREQ / BAUD;
    localparam int HALF     = BIT / 2;
`ifdef UART_RX_MAJORITY_EN
    localparam int SPC = BIT / 16;
    localparam logic [7:0] GLITCH_EXP = 8'hFF;
`else
    localparam int SPC = 0;
    localparam logic [7:0] GLITCH_EXP = 8'hFD;
`endif
    localparam int LAT_EXP = 2 + HALF + 9 * BIT + SPC;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    typedef struct packed {
        logic       fe;
        logic [7:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   fall_cyc = 0;
    bit   lat_pending = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx            (rx),
        .data          (data),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic fe, input logic [7:0] d);
        exp_t e;
        e.fe   = fe;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    // glitch_bit selects a data bit that gets a 20-clk low pulse at its centre.
    task automatic send_frame(input logic [7:0] b, input logic stop_v, input int glitch_bit);
        fall_cyc = cyc;
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 8; i++) begin
            if (i == glitch_bit) begin
                drive_bit(b[i], BIT / 2 - 8);
                drive_bit(1'b0, 20);
                drive_bit(b[i], BIT - BIT / 2 - 12);
            end else begin
                drive_bit(b[i], BIT);
            end
        end
        drive_bit(stop_v, BIT);
    endtask

    always @(negedge clk) begin
        if (reset_n && (data_valid || framing_error)) begin
            exp_t e;
            check("strobe_excl", {31'b0, data_valid & framing_error}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", {30'b0, data_valid, framing_error}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("strobe_kind", {31'b0, framing_error}, {31'b0, e.fe});
                check("rx_data", {24'b0, data}, {24'b0, e.data});
                $display("t=%0t %s data=%02h expected=%02h", $time,
                         framing_error ? "framing_error" : "data_valid", data, e.data);
                if (lat_pending && data_valid) begin
                    int lat;
                    lat = cyc - fall_cyc;
                    check("latency", (lat >= LAT_EXP - 1 && lat <= LAT_EXP + 1) ? LAT_EXP : lat,
                          LAT_EXP);
                    lat_pending = 1'b0;
                end
            end
        end
    end

    initial begin
        int busy_cnt;
        @(negedge clk);
        repeat (4) @(negedge clk);
        check("rst_data", {24'b0, data}, 32'h00);
        check("rst_dv", {31'b0, data_valid}, 32'd0);
        check("rst_fe", {31'b0, framing_error}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);

        // Clean single frame with latency measurement
        push_exp(1'b0, 8'hA5);
        lat_pending = 1'b1;
        send_frame(8'hA5, 1'b1, -1);
        repeat (BIT) @(negedge clk);
        check("a5_pending", exp_q.size(), 32'd0);
        check("a5_busy", {31'b0, busy}, 32'd0);
        check("a5_data", {24'b0, data}, 32'hA5);
        check("a5_lat_seen", {31'b0, lat_pending}, 32'd0);

        // Back-to-back frames with no idle gap
        push_exp(1'b0, 8'h00);
        push_exp(1'b0, 8'hFF);
        push_exp(1'b0, 8'h55);
        send_frame(8'h00, 1'b1, -1);
        send_frame(8'hFF, 1'b1, -1);
        send_frame(8'h55, 1'b1, -1);
        repeat (BIT) @(negedge clk);
        check("b2b_pending", exp_q.size(), 32'd0);
        check("b2b_data", {24'b0, data}, 32'h55);

        // Short low glitch: start rejected, no strobe
        busy_cnt = 0;
        rx = 1'b0;
        for (int i = 0; i < 150 + HALF + 100; i++) begin
            if (i == 150) rx = 1'b1;
            busy_cnt += busy ? 1 : 0;
            @(negedge clk);
        end
        check("glitch_busy_len",
              (busy_cnt >= HALF + SPC - 2 && busy_cnt <= HALF + SPC + 2) ? HALF + SPC : busy_cnt,
              HALF + SPC);
        check("glitch_busy_end", {31'b0, busy}, 32'd0);
        check("glitch_data", {24'b0, data}, 32'h55);

        // Framing error then held-low line
        push_exp(1'b1, 8'h55);
        send_frame(8'h3C, 1'b0, -1);
        repeat (5000) @(negedge clk);
        check("fe_pending", exp_q.size(), 32'd0);
        check("fe_wait_busy", {31'b0, busy}, 32'd1);
        check("fe_data_held", {24'b0, data}, 32'h55);
        rx = 1'b1;
        repeat (10) @(negedge clk);
        check("fe_released", {31'b0, busy}, 32'd0);

        // Reset in the middle of a frame
        drive_bit(1'b0, BIT);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT);
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_busy", {31'b0, busy}, 32'd0);
        check("mid_rst_data", {24'b0, data}, 32'h00);
        check("mid_rst_dv", {31'b0, data_valid}, 32'd0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        push_exp(1'b0, 8'h81);
        send_frame(8'h81, 1'b1, -1);
        repeat (BIT) @(negedge clk);
        check("r81_pending", exp_q.size(), 32'd0);
        check("r81_data", {24'b0, data}, 32'h81);

        // Glitch at the bit-1 centre of 0xFF
        push_exp(1'b0, GLITCH_EXP);
        send_frame(8'hFF, 1'b1, 1);
        repeat (BIT) @(negedge clk);
        check("g_pending", exp_q.size(), 32'd0);
        check("g_data", {24'b0, data}, {24'b0, GLITCH_EXP});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver: the receive-side counterpart of the team's uart_tx, for the iCE40 DHT11/IoT design. It synchronises the asynchronous rx pin to clk and validates the start bit at mid-bit. It samples 8 data bits LSB-first at bit centres, then checks the stop bit. Each good byte produces a one-cycle data_valid strobe; a bad stop bit produces a framing_error strobe. It feeds the command/config path from the host.

Parameters:
CLK_FREQ, 12000000, system clock frequency in Hz
BAUD_RATE, 9600, serial bit rate
(derived localparams) BIT_PERIOD = CLK_FREQ/BAUD_RATE (1250); HALF_PERIOD = BIT_PERIOD/2 (625); counter width 11 bits, sufficient for BIT_PERIOD ≤ 2047

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
rx  input  1  serial line, asynchronous to clk, idle high
data  output  8  last correctly received byte; held until the next good byte
data_valid  output  1  one-cycle pulse: data was updated this cycle
framing_error  output  1  one-cycle pulse: stop bit sampled low
busy  output  1  high whenever state ≠ IDLE

Behaviour:
- Reset (async, reset_n low): state=IDLE; data=8'h00; data_valid=0; framing_error=0; busy=0; counters=0; both synchroniser flops=1 (idle line).
- Synchroniser: 2 flip-flops on rx, giving rx_s. All decisions use rx_s only. Fixed latency is 2 clk.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: when rx_s==0, go to START with baud_counter=0.
- START: count to HALF_PERIOD-1, then sample rx_s.
  - rx_s==0: go to DATA; baud_counter=0, bit_index=0.
  - rx_s==1: glitch; return to IDLE with no strobe.
- DATA: count to BIT_PERIOD-1, then sample rx_s.
  - Shift it in MSB-side: shift_reg <= {rx_s, shift_reg[7:1]}, which yields LSB-first assembly.
  - bit_index increments. After the 8th bit (bit_index 7→8), go to STOP.
- STOP: count to BIT_PERIOD-1, then sample rx_s.
  - rx_s==1: data<=shift_reg; data_valid=1 for exactly one cycle; go to IDLE.
  - rx_s==0: framing_error=1 for one cycle; data unchanged; go to WAIT_IDLE.
- WAIT_IDLE: remain until rx_s==1, then go to IDLE. This covers a break condition or a held-low line, so no false start bits are detected.
- Latency: data_valid rises 2 + HALF_PERIOD + 9×BIT_PERIOD (±1) clk after the rx falling edge. At default parameters that is 11877 ±1.
- Back-to-back frames: the start bit of the next frame may begin half a bit after the stop sample. IDLE re-arms in the cycle after data_valid, so consecutive bytes are never lost.
- data_valid and framing_error are never asserted in the same cycle.
- Reset mid-frame: the frame is discarded immediately and no strobe is issued.
- Strobes are registered outputs, not combinational.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each sample point (start check, data bits, stop bit) takes three rx_s samples at centre-BIT_PERIOD/16, centre, and centre+BIT_PERIOD/16. Default spacing is 78 clk. The bit value is the 2-of-3 majority. The state transition happens at the last sample, so latency grows by BIT_PERIOD/16.
- Undefined: a single sample at the centre point, as described in Behaviour.

Decomposition:
- Shared package uart_pkg holds:
  - BIT_PERIOD and HALF_PERIOD computation functions, shared with uart_tx.
  - The rx state enum/localparams IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4 (3 bits).
- One sub-module, uart_rx_sync: a 2-FF synchroniser with a reset-to-1 parameter, reusable for other async inputs such as the DHT11 data pin.

Test Plan:
- Send 8'hA5 as a clean 8N1 frame at 9600 baud → one data_valid pulse, data==8'hA5, framing_error never high, busy returns to 0.
- Send bytes 8'h00, 8'hFF, 8'h55 back-to-back with a one-bit stop and no idle gap → three data_valid pulses with data 00, FF, 55 in order.
- Drive rx low for 300 clk then high (glitch shorter than HALF_PERIOD) → no strobe; state returns to IDLE; busy high for about 627 clk only.
- Send 8'h3C with the stop bit forced low, then hold rx low for 5000 clk → one framing_error pulse, data keeps its previous value, no new frame until rx returns high.
- Assert reset_n low mid-byte (after bit 3), then release and send 8'h81 → no strobe from the aborted frame; 8'h81 received correctly.
- With UART_RX_MAJORITY_EN defined, inject a 20-clk low glitch at a bit-1 centre of 8'hFF → data==8'hFF. The same stimulus without the macro gives data==8'hFD (bit 1 corrupted).
